deparser_unit: RTL and testbench

Header deparser: the write-side counterpart of the parser-unit chain. Captures a 2048-bit message template, accepts header fields one per cycle via valid/ready, and overlays each MSB-first at a running bit offset. It then presents the rebuilt message with its final offset to egress. It sits after the match-action stages and re-emits headers (VLAN 0x8100, MPLS 0x8847, IPv4/IPv6/ARP, L4) into the message format the parser chain consumes.

---
 rtl/deparser_pkg.sv | 28 ++
 rtl/deparser_insert.sv | 45 ++++
 rtl/deparser_unit.sv | 118 +++++++++++
 tb/tb_deparser_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/deparser_pkg.sv
// ============================================================================
// Module : deparser_pkg
// Brief  : Shared widths, state encoding and length helper for the deparser.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package deparser_pkg;

    localparam int MSG_W         = 2048;
    localparam int HDR_W         = 144;
    localparam int OFF_W         = 12;
    localparam int LEN_W         = 5;
    localparam int MAX_HDR_BYTES = 18;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_OUT     = 2'd2
    } state_t;

    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MAX_HDR_BYTES)) ? LEN_W'(MAX_HDR_BYTES) : len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/deparser_insert.sv
// ============================================================================
// Module : deparser_insert
// Brief  : Combinational overlay of one left-aligned header into the message.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module deparser_insert
    import deparser_pkg::*;
(
    input  logic [MSG_W-1:0] i_buf,
    input  logic [OFF_W-1:0] i_off,
    input  logic [HDR_W-1:0] i_hdr_data,
    input  logic [LEN_W-1:0] i_hdr_len,
    output logic [MSG_W-1:0] o_buf,
    output logic [OFF_W-1:0] o_off,
    output logic             o_drop
);

    logic [LEN_W-1:0] w_len;
    logic [HDR_W-1:0] w_hmask;
    logic [MSG_W-1:0] w_mask;
    logic [MSG_W-1:0] w_data;
    logic [OFF_W:0]   w_end;

    assign w_len = sat_len(i_hdr_len);

    generate
        for (genvar k = 0; k < MAX_HDR_BYTES; k++) begin : g_byte
            assign w_hmask[HDR_W-1-8*k -: 8] = {8{LEN_W'(k) < w_len}};
        end
    endgenerate

    // Offsets are byte aligned, so bytes shifted past bit 0 drop out whole.
    assign w_mask = {w_hmask, {(MSG_W-HDR_W){1'b0}}} >> i_off;
    assign w_data = {i_hdr_data & w_hmask, {(MSG_W-HDR_W){1'b0}}} >> i_off;
    assign o_buf  = (i_buf & ~w_mask) | w_data;

    assign w_end  = {1'b0, i_off} + {{(OFF_W+1-LEN_W-3){1'b0}}, w_len, 3'b000};
    assign o_drop = (w_len != '0) && (w_end > (OFF_W+1)'(MSG_W));
    assign o_off  = (w_end > (OFF_W+1)'(MSG_W)) ? OFF_W'(MSG_W) : w_end[OFF_W-1:0];

endmodule

`default_nettype wire

// File: rtl/deparser_unit.sv
// ============================================================================
// Module : deparser_unit
// Brief  : Header deparser: template capture, header overlay FSM, egress hold.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module deparser_unit
    import deparser_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    output logic             o_start_ready,
    input  logic [MSG_W-1:0] i_msg_in,
    input  logic [OFF_W-1:0] i_base_offset,
    input  logic             i_hdr_valid,
    output logic             o_hdr_ready,
    input  logic [HDR_W-1:0] i_hdr_data,
    input  logic [LEN_W-1:0] i_hdr_len,
    input  logic             i_hdr_last,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [MSG_W-1:0] o_message_out,
    output logic [OFF_W-1:0] o_offset_out,
    output logic             o_overflow
);

    state_t           r_state;
    logic [MSG_W-1:0] r_buf;
    logic [OFF_W-1:0] r_off;
    logic             r_ovf;
    logic             r_start_ready;
    logic             r_hdr_ready;
    logic             r_out_valid;

    logic [MSG_W-1:0] w_buf;
    logic [OFF_W-1:0] w_off;
    logic             w_drop;
    logic [OFF_W-1:0] w_base;
    logic             w_unused_base;

    assign w_base        = {i_base_offset[OFF_W-1:3], 3'b000};
    assign w_unused_base = ^i_base_offset[2:0];

    deparser_insert u_insert (
        .i_buf      (r_buf),
        .i_off      (r_off),
        .i_hdr_data (i_hdr_data),
        .i_hdr_len  (i_hdr_len),
        .o_buf      (w_buf),
        .o_off      (w_off),
        .o_drop     (w_drop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_buf         <= '0;
            r_off         <= '0;
            r_ovf         <= 1'b0;
            r_start_ready <= 1'b1;
            r_hdr_ready   <= 1'b0;
            r_out_valid   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_buf         <= i_msg_in;
                        // A base past the end behaves like an exhausted message.
                        r_off         <= (w_base > OFF_W'(MSG_W)) ? OFF_W'(MSG_W) : w_base;
                        r_ovf         <= 1'b0;
                        r_state       <= ST_COLLECT;
                        r_start_ready <= 1'b0;
                        r_hdr_ready   <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (i_hdr_valid) begin
                        r_buf <= w_buf;
                        r_off <= w_off;
                        if (w_drop) begin
                            r_ovf <= 1'b1;
                        end
                        if (i_hdr_last) begin
                            r_state     <= ST_OUT;
                            r_hdr_ready <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                ST_OUT: begin
                    if (i_out_ready) begin
                        r_state       <= ST_IDLE;
                        r_out_valid   <= 1'b0;
                        r_start_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_start_ready <= 1'b1;
                    r_hdr_ready   <= 1'b0;
                    r_out_valid   <= 1'b0;
                end
            endcase
        end
    end

    assign o_start_ready = r_start_ready;
    assign o_hdr_ready   = r_hdr_ready;
    assign o_out_valid   = r_out_valid;
    assign o_message_out = r_buf;
    assign o_offset_out  = r_off;
    assign o_overflow    = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_deparser_unit.sv
// ============================================================================
// Module : tb_deparser_unit
// Brief  : Scoreboard bench for deparser_unit with a byte-level reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_deparser_unit;
    import deparser_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_start;
    logic             o_start_ready;
    logic [MSG_W-1:0] i_msg_in;
    logic [OFF_W-1:0] i_base_offset;
    logic             i_hdr_valid;
    logic             o_hdr_ready;
    logic [HDR_W-1:0] i_hdr_data;
    logic [LEN_W-1:0] i_hdr_len;
    logic             i_hdr_last;
    logic             o_out_valid;
    logic             i_out_ready;
    logic [MSG_W-1:0] o_message_out;
    logic [OFF_W-1:0] o_offset_out;
    logic             o_overflow;

    always #5 clk = ~clk;

    deparser_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .o_start_ready (o_start_ready),
        .i_msg_in      (i_msg_in),
        .i_base_offset (i_base_offset),
        .i_hdr_valid   (i_hdr_valid),
        .o_hdr_ready   (o_hdr_ready),
        .i_hdr_data    (i_hdr_data),
        .i_hdr_len     (i_hdr_len),
        .i_hdr_last    (i_hdr_last),
        .o_out_valid   (o_out_valid),
        .i_out_ready   (i_out_ready),
        .o_message_out (o_message_out),
        .o_offset_out  (o_offset_out),
        .o_overflow    (o_overflow)
    );

    typedef struct {
        logic [MSG_W-1:0] msg;
        int               off;
        logic             ovf;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   total = 0;
    int   bad   = 0;

    // Reference model: message as a bit vector addressed MSB-first by byte.
    logic [MSG_W-1:0] m_msg;
    int               m_off;
    logic             m_ovf;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_msg(input string name, input logic [MSG_W-1:0] act,
                             input logic [MSG_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            for (int i = 0; i < MSG_W/32; i++) begin
                if (act[MSG_W-1-32*i -: 32] !== exp[MSG_W-1-32*i -: 32]) begin
                    $display("FAIL %s: word %0d (from MSB) got %08h expected %08h",
                             name, i, act[MSG_W-1-32*i -: 32], exp[MSG_W-1-32*i -: 32]);
                    break;
                end
            end
        end
    endtask

    task automatic m_start(input logic [MSG_W-1:0] tmpl, input int base);
        m_msg = tmpl;
        m_off = (base / 8) * 8;
        if (m_off > MSG_W) m_off = MSG_W;
        m_ovf = 1'b0;
    endtask

    task automatic m_hdr(input logic [HDR_W-1:0] data, input int len);
        int n;
        n = (len > MAX_HDR_BYTES) ? MAX_HDR_BYTES : len;
        for (int k = 0; k < n; k++) begin
            if (m_off + 8*k + 8 <= MSG_W)
                m_msg[MSG_W-1-(m_off+8*k) -: 8] = data[HDR_W-1-8*k -: 8];
            else
                m_ovf = 1'b1;
        end
        m_off = m_off + 8*n;
        if (m_off > MSG_W) m_off = MSG_W;
    endtask

    function automatic logic [MSG_W-1:0] rand_msg();
        logic [MSG_W-1:0] m;
        for (int i = 0; i < MSG_W/32; i++) m[32*i +: 32] = $urandom;
        return m;
    endfunction

    function automatic logic [HDR_W-1:0] rand_hdr();
        logic [159:0] t;
        for (int i = 0; i < 5; i++) t[32*i +: 32] = $urandom;
        return t[HDR_W-1:0];
    endfunction

    task automatic drv_start(input logic [MSG_W-1:0] tmpl, input int base);
        int w = 0;
        while (!o_start_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 50) check("start_ready timeout", 64'(o_start_ready), 64'd1);
        i_start       = 1'b1;
        i_msg_in      = tmpl;
        i_base_offset = OFF_W'(base);
        @(posedge clk); #1;
        i_start = 1'b0;
        m_start(tmpl, base);
        check("hdr_ready after start", 64'(o_hdr_ready), 64'd1);
    endtask

    task automatic drv_hdr(input logic [HDR_W-1:0] data, input int len, input logic last);
        exp_t e;
        i_hdr_valid = 1'b1;
        i_hdr_data  = data;
        i_hdr_len   = LEN_W'(len);
        i_hdr_last  = last;
        @(posedge clk); #1;
        i_hdr_valid = 1'b0;
        i_hdr_last  = 1'b0;
        m_hdr(data, len);
        if (last) begin
            e.msg = m_msg; e.off = m_off; e.ovf = m_ovf;
            sb.push_back(e);
            last_exp = e;
            check("out_valid after last", 64'(o_out_valid), 64'd1);
        end else begin
            check("hdr_ready mid packet", 64'(o_hdr_ready), 64'd1);
        end
    endtask

    task automatic drain(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("out_valid held", 64'(o_out_valid), 64'd1);
            check("offset held", 64'(o_offset_out), 64'(last_exp.off));
        end
        i_out_ready = 1'b1;
        @(posedge clk); #1;
        i_out_ready = 1'b0;
        check("start_ready after out", 64'(o_start_ready), 64'd1);
        check("out_valid cleared", 64'(o_out_valid), 64'd0);
    endtask

    // Monitor: compares every accepted output against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && o_out_valid && i_out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected output", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_msg("message_out", o_message_out, e.msg);
                check("offset_out", 64'(o_offset_out), 64'(e.off));
                check("overflow", 64'(o_overflow), 64'(e.ovf));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MSG_W-1:0] ones;
        logic [159:0]     ip;
        logic [HDR_W-1:0] h;
        int               nh, len;

        ones          = '1;
        rst_n         = 1'b0;
        i_start       = 1'b0;
        i_msg_in      = '0;
        i_base_offset = '0;
        i_hdr_valid   = 1'b0;
        i_hdr_data    = '0;
        i_hdr_len     = '0;
        i_hdr_last    = 1'b0;
        i_out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset start_ready", 64'(o_start_ready), 64'd1);
        check("reset hdr_ready", 64'(o_hdr_ready), 64'd0);
        check("reset out_valid", 64'(o_out_valid), 64'd0);
        check_msg("reset message_out", o_message_out, '0);
        check("reset offset_out", 64'(o_offset_out), 64'd0);
        check("reset overflow", 64'(o_overflow), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single VLAN tag on zero template
        drv_start('0, 96);
        drv_hdr({32'h8100_0064, 112'h0}, 4, 1'b1);
        check("vlan slice", 64'(o_message_out[1951 -: 32]), 64'h8100_0064);
        check("vlan offset", 64'(o_offset_out), 64'd128);
        drain(0);

        // VLAN + MPLS + IPv4 split 18+2, back to back
        ip = 160'h4500_0054_1c46_4000_4006_b1e6_c0a8_0001_c0a8_00c7;
        drv_start(rand_msg(), 96);
        drv_hdr({32'h8100_0064, 112'h0}, 4, 1'b0);
        drv_hdr({32'h0001_0140, 112'h0}, 4, 1'b0);
        drv_hdr(ip[159:16], 18, 1'b0);
        drv_hdr({ip[15:0], 128'h0}, 2, 1'b1);
        drain(0);

        // Tail truncation on all-ones template
        drv_start(ones, 2032);
        drv_hdr({32'hAABB_CCDD, 112'h0}, 4, 1'b1);
        check("tail bytes", 64'(o_message_out[15:0]), 64'hAABB);
        check("tail offset", 64'(o_offset_out), 64'd2048);
        check("tail overflow", 64'(o_overflow), 64'd1);
        drain(0);

        // Zero-length last beat leaves template untouched
        drv_start(rand_msg(), 301);
        drv_hdr(rand_hdr(), 0, 1'b1);
        drain(0);

        // Back-pressure: start and hdr_valid pulsed while held in OUT
        drv_start(rand_msg(), 40);
        drv_hdr(rand_hdr(), 7, 1'b1);
        for (int i = 0; i < 5; i++) begin
            i_start     = 1'b1;
            i_msg_in    = rand_msg();
            i_hdr_valid = 1'b1;
            i_hdr_data  = rand_hdr();
            i_hdr_len   = 5'd4;
            @(posedge clk); #1;
            check("hold out_valid", 64'(o_out_valid), 64'd1);
            check("hold start_ready", 64'(o_start_ready), 64'd0);
            check("hold hdr_ready", 64'(o_hdr_ready), 64'd0);
            check_msg("hold message", o_message_out, last_exp.msg);
            check("hold offset", 64'(o_offset_out), 64'(last_exp.off));
        end
        i_start     = 1'b0;
        i_hdr_valid = 1'b0;
        drain(0);

        // Asynchronous reset mid-packet discards it
        drv_start(rand_msg(), 64);
        drv_hdr(rand_hdr(), 6, 1'b0);
        drv_hdr(rand_hdr(), 6, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rst start_ready", 64'(o_start_ready), 64'd1);
        check("rst hdr_ready", 64'(o_hdr_ready), 64'd0);
        check("rst out_valid", 64'(o_out_valid), 64'd0);
        check_msg("rst message_out", o_message_out, '0);
        check("rst offset_out", 64'(o_offset_out), 64'd0);
        check("rst overflow", 64'(o_overflow), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drv_start(rand_msg(), 200);
        drv_hdr(rand_hdr(), 10, 1'b0);
        drv_hdr(rand_hdr(), 18, 1'b1);
        drain(0);

        // Randomized packets, including oversize lengths and late offsets
        for (int p = 0; p < 40; p++) begin
            drv_start(rand_msg(), (p % 5 == 0) ? $urandom_range(1900, 2200) : $urandom_range(0, 1800));
            nh = $urandom_range(1, 6);
            for (int k = 0; k < nh; k++) begin
                len = ($urandom_range(0, 7) == 0) ? $urandom_range(19, 31) : $urandom_range(0, 18);
                h = rand_hdr();
                drv_hdr(h, len, k == nh - 1);
            end
            drain($urandom_range(0, 3));
        end

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
